// File: rtl/sw_pkg.sv
// ============================================================================
// sw_pkg: shared state encodings and parameter defaults for the stopwatch front end. Rev 1.0
// ============================================================================
`default_nettype none

package sw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 20;

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// sw_debounce: 2-flop synchronizer, level debouncer and one-cycle press pulse. Rev 1.0
// ============================================================================
`default_nettype none

module sw_debounce
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      press_q  <= db_q & ~db_dly_q;
      // Only an unbroken run of differing samples can flip the stable level.
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q  <= ~db_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/sw_control.sv
// ============================================================================
// sw_control: button front end and stopwatch mode FSM. Lap/clear support is
// enabled by defining SW_LAP_EN. Rev 1.0
// ============================================================================
`default_nettype none

module sw_control
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic       count_en,
  output logic       freeze,
  output logic       clr,
  output logic [1:0] mode
);

  logic      ss_p;
  logic      lap_p;
  sw_state_e state_q;
  sw_state_e state_d;
  logic      clr_d;
  logic      count_en_q;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_ss (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_ss),
    .press_o(ss_p)
  );

`ifdef SW_LAP_EN
  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_lap (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_lap),
    .press_o(lap_p)
  );
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign lap_p      = 1'b0;
`endif

  // Start/stop takes priority when both presses land in the same cycle.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (ss_p) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = STOP;
        LAP:     state_d = STOP;
        STOP:    state_d = RUN;
        default: state_d = state_q;
      endcase
    end else if (lap_p) begin
      case (state_q)
        IDLE: clr_d = 1'b1;
        RUN:  state_d = LAP;
        LAP:  state_d = RUN;
        STOP: begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_en_q <= (state_d == RUN) || (state_d == LAP);
    end
  end

`ifdef SW_LAP_EN
  logic freeze_q;
  logic clr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeze_q <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      freeze_q <= (state_d == LAP);
      clr_q    <= clr_d;
    end
  end

  assign freeze = freeze_q;
  assign clr    = clr_q;
`else
  logic unused_clr;
  assign unused_clr = clr_d;
  assign freeze     = 1'b0;
  assign clr        = 1'b0;
`endif

  assign count_en = count_en_q;
  assign mode     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_control.sv
// ============================================================================
// tb_sw_control: self-checking bench for sw_control with DEBOUNCE_CYCLES=4. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sw_control;

  localparam int D = 4;
`ifdef SW_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lap = 1'b0;
  logic       count_en;
  logic       freeze;
  logic       clr;
  logic [1:0] mode;

  sw_control #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_ss  (btn_ss),
    .btn_lap (btn_lap),
    .count_en(count_en),
    .freeze  (freeze),
    .clr     (clr),
    .mode    (mode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the last D synchronized samples
  // (raw delayed two edges) all disagree with it; the mode moves two edges later.
  bit q_ss[$];
  bit q_lap[$];
  bit m_db_ss, m_db_lap, m_clr;
  int m_e, m_fire_ss, m_fire_lap, m_mode;

  function automatic void model_reset();
    q_ss.delete();
    q_lap.delete();
    for (int i = 0; i < D + 2; i++) begin
      q_ss.push_back(1'b0);
      q_lap.push_back(1'b0);
    end
    m_db_ss = 0; m_db_lap = 0; m_clr = 0;
    m_e = 0; m_fire_ss = -1; m_fire_lap = -1; m_mode = 0;
  endfunction

  function automatic bit flips(input bit db, input bit q[$]);
    for (int j = 2; j < D + 2; j++)
      if (q[j] == db) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_edge(input bit ss, input bit lap);
    bit sp, lp;
    sp = (m_fire_ss == m_e);
    lp = LAP_EN && (m_fire_lap == m_e);
    m_clr = 0;
    if (sp) begin
      m_mode = (m_mode == 1 || m_mode == 2) ? 3 : 1;
    end else if (lp) begin
      case (m_mode)
        0: m_clr = 1;
        1: m_mode = 2;
        2: m_mode = 1;
        default: begin m_mode = 0; m_clr = 1; end
      endcase
    end
    q_ss.push_front(ss);   void'(q_ss.pop_back());
    q_lap.push_front(lap); void'(q_lap.pop_back());
    if (flips(m_db_ss, q_ss)) begin
      m_db_ss = !m_db_ss;
      if (m_db_ss) m_fire_ss = m_e + 2;
    end
    if (flips(m_db_lap, q_lap)) begin
      m_db_lap = !m_db_lap;
      if (m_db_lap) m_fire_lap = m_e + 2;
    end
    m_e++;
  endfunction

  // Called at a falling edge; applies one rising edge and checks against the model.
  task automatic tick(input bit ss, input bit lap);
    logic [1:0] mm;
    logic [4:0] e5;
    btn_ss  = ss;
    btn_lap = lap;
    @(posedge clk);
    model_edge(ss, lap);
    @(negedge clk);
    mm = m_mode[1:0];
    e5 = {mm, (m_mode == 1 || m_mode == 2), (m_mode == 2), m_clr};
    chk("model {mode,en,frz,clr}", {27'd0, mode, count_en, freeze, clr}, {27'd0, e5});
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 chk("async_reset", {28'd0, mode, count_en, freeze, clr}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press(input bit ss, input bit lap, output int clrs);
    clrs = 0;
    repeat (6) begin tick(ss, lap); clrs += int'(clr); end
    repeat (8) begin tick(1'b0, 1'b0); clrs += int'(clr); end
  endtask

  typedef struct {
    bit ss;
    bit lap;
    int mode;
    bit en;
    bit frz;
    int clrs;
  } vec_t;

  vec_t vt[11];

  initial begin
    int lat, clrs, changes;
    logic [1:0] prev;
    bit vs, vl;
    int rs, rl;

    vt[0]  = '{1, 0, 1, 1, 0, 0};
    vt[1]  = '{0, 1, LAP_EN ? 2 : 1, 1, LAP_EN, 0};
    vt[2]  = '{0, 1, 1, 1, 0, 0};
    vt[3]  = '{0, 1, LAP_EN ? 2 : 1, 1, LAP_EN, 0};
    vt[4]  = '{1, 0, 3, 0, 0, 0};
    vt[5]  = '{1, 0, 1, 1, 0, 0};
    vt[6]  = '{1, 0, 3, 0, 0, 0};
    vt[7]  = '{0, 1, LAP_EN ? 0 : 3, 0, 0, LAP_EN ? 1 : 0};
    vt[8]  = '{0, 1, LAP_EN ? 0 : 3, 0, 0, LAP_EN ? 1 : 0};
    vt[9]  = '{1, 0, 1, 1, 0, 0};
    vt[10] = '{1, 1, 3, 0, 0, 0};

    @(negedge clk);
    do_reset();
    repeat (6) tick(1'b0, 1'b0);
    chk("idle_mode", {30'd0, mode}, 32'd0);
    chk("idle_en", {31'd0, count_en}, 32'd0);

    // Bounces shorter than D are rejected, then one clean press
    repeat (2) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    repeat (10) tick(1'b0, 1'b0);
    chk("bounce_mode", {30'd0, mode}, 32'd0);
    changes = 0;
    prev = mode;
    for (int t = 0; t < 16; t++) begin
      tick(t < 6, 1'b0);
      if (mode != prev) changes++;
      prev = mode;
    end
    chk("bounce_press_changes", changes, 1);
    chk("bounce_press_mode", {30'd0, mode}, 32'd1);

    // Press latency from first sampling edge
    do_reset();
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      tick(t < 10, 1'b0);
      if (lat < 0 && mode == 2'd1) lat = t;
    end
    chk("start_latency", lat, 7);
    chk("start_en", {31'd0, count_en}, 32'd1);
    press(1'b1, 1'b0, clrs);
    chk("stop_mode", {30'd0, mode}, 32'd3);
    chk("stop_en", {31'd0, count_en}, 32'd0);
    press(1'b1, 1'b0, clrs);
    chk("resume_mode", {30'd0, mode}, 32'd1);
    chk("resume_no_clr", clrs, 0);

    // Table of press sequences from IDLE
    do_reset();
    repeat (4) tick(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      press(vt[i].ss, vt[i].lap, clrs);
      chk($sformatf("vec%0d_mode", i), {30'd0, mode}, vt[i].mode);
      chk($sformatf("vec%0d_en_frz", i), {30'd0, count_en, freeze}, {30'd0, vt[i].en, vt[i].frz});
      chk($sformatf("vec%0d_clr_cycles", i), clrs, vt[i].clrs);
    end

    // Reset mid-debounce with the button still held
    repeat (3) tick(1'b1, 1'b0);
    do_reset();
    repeat (10) tick(1'b1, 1'b0);
    chk("held_after_reset", {30'd0, mode}, 32'd1);
    repeat (10) tick(1'b0, 1'b0);

    // Random run-length stimulus against the model
    rs = 0; rl = 0; vs = 0; vl = 0;
    for (int i = 0; i < 2500; i++) begin
      if (rs == 0) begin vs = bit'($urandom_range(0, 1)); rs = $urandom_range(1, 9); end
      if (rl == 0) begin vl = bit'($urandom_range(0, 1)); rl = $urandom_range(1, 9); end
      rs--; rl--;
      if ($urandom_range(0, 499) == 0) do_reset();
      tick(vs, vl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
